// File: rtl/axi_rd_arbiter_if.sv
// Bundles for the arbiter: a core-side SRAM-like read port and a single-beat AXI read channel.
// The arbiter sits on the slave side of the core ports and the master side of the AXI port.
interface sram_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, size, input addr_ok, data_ok, rdata);
  modport slave  (input req, addr, size, output addr_ok, data_ok, rdata);
endinterface

interface axi_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (output arid, araddr, arsize, arlen, arvalid, rready,
                  input arready, rid, rdata, rlast, rvalid);
  modport slave  (input arid, araddr, arsize, arlen, arvalid, rready,
                  output arready, rid, rdata, rlast, rvalid);
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI read channel between the
// instruction-fetch and data-load ports; one transaction outstanding at a time.
//
//   state  | meaning
//   IDLE   | waiting for a request; grants one and latches its address
//   ADDR   | arvalid high, holding address/ID stable until arready
//   DATA   | rready high, waiting for the single read beat
module axi_rd_arbiter #(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic     clk,
  input  logic     rst,
  sram_rd_if.slave inst_if,
  sram_rd_if.slave data_if,
  axi_rd_if.master axi_if,
  output logic     rid_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last_data;
  logic              r_owner_data;
  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arsize;
  logic [3:0]        r_arid;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_inst_data_ok;
  logic              r_data_data_ok;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;
  logic              r_rid_err;

  logic w_idle;
  logic w_grant_inst;
  logic w_grant_data;
  logic w_unused;

  // Gated by rst so a request seen during reset is never acknowledged.
  assign w_idle = (r_state == S_IDLE) && !rst;

  // On contention the port that did not win last time gets the grant.
  assign w_grant_inst = w_idle && inst_if.req && (!data_if.req ||  r_last_data);
  assign w_grant_data = w_idle && data_if.req && (!inst_if.req || !r_last_data);

  // Single-beat bursts only, so rlast carries no information.
  assign w_unused = axi_if.rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_last_data    <= 1'b0;
      r_owner_data   <= 1'b0;
      r_araddr       <= '0;
      r_arsize       <= 3'd0;
      r_arid         <= 4'd0;
      r_arvalid      <= 1'b0;
      r_rready       <= 1'b0;
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
      r_inst_rdata   <= '0;
      r_data_rdata   <= '0;
      r_rid_err      <= 1'b0;
    end else begin
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_data) begin
            r_araddr     <= data_if.addr;
            r_arsize     <= {1'b0, data_if.size};
            r_arid       <= ID_DATA;
            r_owner_data <= 1'b1;
            r_last_data  <= 1'b1;
            r_arvalid    <= 1'b1;
            r_state      <= S_ADDR;
          end else if (w_grant_inst) begin
            r_araddr     <= inst_if.addr;
            r_arsize     <= {1'b0, inst_if.size};
            r_arid       <= ID_INST;
            r_owner_data <= 1'b0;
            r_last_data  <= 1'b0;
            r_arvalid    <= 1'b1;
            r_state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (axi_if.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (axi_if.rvalid) begin
            r_rready <= 1'b0;
            if (r_owner_data) begin
              r_data_rdata   <= axi_if.rdata;
              r_data_data_ok <= 1'b1;
            end else begin
              r_inst_rdata   <= axi_if.rdata;
              r_inst_data_ok <= 1'b1;
            end
            // A mismatched ID still completes; it is only flagged.
            if (axi_if.rid != r_arid) begin
              r_rid_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
        end
      endcase
    end
  end

  assign inst_if.addr_ok = w_grant_inst;
  assign data_if.addr_ok = w_grant_data;
  assign inst_if.data_ok = r_inst_data_ok;
  assign data_if.data_ok = r_data_data_ok;
  assign inst_if.rdata   = r_inst_rdata;
  assign data_if.rdata   = r_data_rdata;

  assign axi_if.arid    = r_arid;
  assign axi_if.araddr  = r_araddr;
  assign axi_if.arsize  = r_arsize;
  assign axi_if.arlen   = 8'd0;
  assign axi_if.arvalid = r_arvalid;
  assign axi_if.rready  = r_rready;

  assign rid_err = r_rid_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: each task drives one scenario cycle by cycle
// and compares outputs at the falling edge against hand-computed values.
module tb_axi_rd_arbiter;

  logic clk;
  logic rst;
  logic rid_err;
  int   vec_cnt;
  int   err_cnt;

  sram_rd_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
  sram_rd_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
  axi_rd_if  #(.ADDR_W(32), .DATA_W(32)) axi_if ();

  axi_rd_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .ID_INST(4'd0),
    .ID_DATA(4'd1)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .inst_if(inst_if.slave),
    .data_if(data_if.slave),
    .axi_if (axi_if.master),
    .rid_err(rid_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_if.req    = 1'b0;
    inst_if.addr   = 32'h0;
    inst_if.size   = 2'd0;
    data_if.req    = 1'b0;
    data_if.addr   = 32'h0;
    data_if.size   = 2'd0;
    axi_if.arready = 1'b0;
    axi_if.rid     = 4'd0;
    axi_if.rdata   = 32'h0;
    axi_if.rlast   = 1'b1;
    axi_if.rvalid  = 1'b0;
  endtask

  // Leaves the bench just after a rising edge with reset released.
  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_cnt++; if (axi_if.arvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_arvalid got %0b want 0", axi_if.arvalid); end
    vec_cnt++; if (axi_if.rready !== 1'b0) begin err_cnt++; $display("FAIL rst_rready got %0b want 0", axi_if.rready); end
    vec_cnt++; if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0) begin err_cnt++; $display("FAIL rst_data_ok got %0b/%0b want 0/0", inst_if.data_ok, data_if.data_ok); end
    vec_cnt++; if (inst_if.rdata !== 32'h0 || data_if.rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata got %h/%h want 0/0", inst_if.rdata, data_if.rdata); end
    vec_cnt++; if (axi_if.araddr !== 32'h0 || axi_if.arid !== 4'd0 || axi_if.arsize !== 3'd0) begin err_cnt++; $display("FAIL rst_ar got %h/%h/%h want 0/0/0", axi_if.araddr, axi_if.arid, axi_if.arsize); end
    vec_cnt++; if (axi_if.arlen !== 8'd0) begin err_cnt++; $display("FAIL rst_arlen got %h want 0", axi_if.arlen); end
    vec_cnt++; if (rid_err !== 1'b0) begin err_cnt++; $display("FAIL rst_rid_err got %0b want 0", rid_err); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    inst_if.req = 1'b1; inst_if.addr = 32'hBFC00000; inst_if.size = 2'd2;
    axi_if.arready = 1'b1; axi_if.rvalid = 1'b1; axi_if.rid = 4'd0; axi_if.rdata = 32'h3C080001;
    @(negedge clk);
    vec_cnt++; if (inst_if.addr_ok !== 1'b1) begin err_cnt++; $display("FAIL t1_c0_addr_ok got %0b want 1", inst_if.addr_ok); end
    vec_cnt++; if (data_if.addr_ok !== 1'b0) begin err_cnt++; $display("FAIL t1_c0_data_addr_ok got %0b want 0", data_if.addr_ok); end
    step();
    inst_if.req = 1'b0;
    @(negedge clk);
    vec_cnt++; if (axi_if.arvalid !== 1'b1) begin err_cnt++; $display("FAIL t1_c1_arvalid got %0b want 1", axi_if.arvalid); end
    vec_cnt++; if (axi_if.araddr !== 32'hBFC00000) begin err_cnt++; $display("FAIL t1_c1_araddr got %h want bfc00000", axi_if.araddr); end
    vec_cnt++; if (axi_if.arsize !== 3'd2 || axi_if.arid !== 4'd0) begin err_cnt++; $display("FAIL t1_c1_arsize_arid got %0d/%0d want 2/0", axi_if.arsize, axi_if.arid); end
    vec_cnt++; if (axi_if.rready !== 1'b0) begin err_cnt++; $display("FAIL t1_c1_rready got %0b want 0", axi_if.rready); end
    step();
    @(negedge clk);
    vec_cnt++; if (axi_if.rready !== 1'b1 || axi_if.arvalid !== 1'b0) begin err_cnt++; $display("FAIL t1_c2_rready_arvalid got %0b/%0b want 1/0", axi_if.rready, axi_if.arvalid); end
    vec_cnt++; if (inst_if.data_ok !== 1'b0) begin err_cnt++; $display("FAIL t1_c2_data_ok got %0b want 0", inst_if.data_ok); end
    step();
    @(negedge clk);
    vec_cnt++; if (inst_if.data_ok !== 1'b1) begin err_cnt++; $display("FAIL t1_c3_data_ok got %0b want 1", inst_if.data_ok); end
    vec_cnt++; if (inst_if.rdata !== 32'h3C080001) begin err_cnt++; $display("FAIL t1_c3_rdata got %h want 3c080001", inst_if.rdata); end
    vec_cnt++; if (data_if.data_ok !== 1'b0 || axi_if.rready !== 1'b0) begin err_cnt++; $display("FAIL t1_c3_other got %0b/%0b want 0/0", data_if.data_ok, axi_if.rready); end
    step();
    @(negedge clk);
    vec_cnt++; if (inst_if.data_ok !== 1'b0) begin err_cnt++; $display("FAIL t1_c4_data_ok got %0b want 0", inst_if.data_ok); end
  endtask

  task automatic test_round_robin();
    logic exp_d, exp_i, prev_d, prev_i;
    apply_reset();
    inst_if.req = 1'b1; inst_if.addr = 32'h00001000; inst_if.size = 2'd2;
    data_if.req = 1'b1; data_if.addr = 32'h00002000; data_if.size = 2'd2;
    axi_if.arready = 1'b1; axi_if.rvalid = 1'b1; axi_if.rid = 4'd0; axi_if.rdata = 32'h11112222;
    for (int k = 0; k < 6; k++) begin
      exp_d  = (k % 2 == 0);
      exp_i  = (k % 2 == 1);
      prev_d = (k > 0) && ((k - 1) % 2 == 0);
      prev_i = (k > 0) && ((k - 1) % 2 == 1);
      @(negedge clk);
      vec_cnt++; if (data_if.addr_ok !== exp_d || inst_if.addr_ok !== exp_i) begin err_cnt++; $display("FAIL t2_grant%0d got d%0b/i%0b want d%0b/i%0b", k, data_if.addr_ok, inst_if.addr_ok, exp_d, exp_i); end
      vec_cnt++; if (data_if.data_ok !== prev_d || inst_if.data_ok !== prev_i) begin err_cnt++; $display("FAIL t2_data_ok%0d got d%0b/i%0b want d%0b/i%0b", k, data_if.data_ok, inst_if.data_ok, prev_d, prev_i); end
      step();
      @(negedge clk);
      vec_cnt++; if (axi_if.arid !== (exp_d ? 4'd1 : 4'd0) || axi_if.araddr !== (exp_d ? 32'h2000 : 32'h1000)) begin err_cnt++; $display("FAIL t2_ar%0d got id%0d/%h want id%0d", k, axi_if.arid, axi_if.araddr, exp_d); end
      vec_cnt++; if (data_if.addr_ok !== 1'b0 || inst_if.addr_ok !== 1'b0) begin err_cnt++; $display("FAIL t2_addr_ok_addr%0d got %0b/%0b want 0/0", k, data_if.addr_ok, inst_if.addr_ok); end
      step();
      @(negedge clk);
      vec_cnt++; if (data_if.addr_ok !== 1'b0 || inst_if.addr_ok !== 1'b0) begin err_cnt++; $display("FAIL t2_addr_ok_data%0d got %0b/%0b want 0/0", k, data_if.addr_ok, inst_if.addr_ok); end
      step();
    end
  endtask

  task automatic test_stall();
    apply_reset();
    inst_if.req = 1'b1; inst_if.addr = 32'h00004000; inst_if.size = 2'd2;
    @(negedge clk);
    vec_cnt++; if (inst_if.addr_ok !== 1'b1) begin err_cnt++; $display("FAIL t3_c0_addr_ok got %0b want 1", inst_if.addr_ok); end
    step();
    inst_if.req = 1'b0;
    data_if.req = 1'b1; data_if.addr = 32'h00003000; data_if.size = 2'd1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      vec_cnt++; if (axi_if.arvalid !== 1'b1 || axi_if.araddr !== 32'h4000 || axi_if.arid !== 4'd0) begin err_cnt++; $display("FAIL t3_hold%0d got %0b/%h/%0d want 1/4000/0", c, axi_if.arvalid, axi_if.araddr, axi_if.arid); end
      vec_cnt++; if (data_if.addr_ok !== 1'b0) begin err_cnt++; $display("FAIL t3_hold_addr_ok%0d got %0b want 0", c, data_if.addr_ok); end
      step();
    end
    axi_if.arready = 1'b1;
    @(negedge clk);
    vec_cnt++; if (data_if.addr_ok !== 1'b0) begin err_cnt++; $display("FAIL t3_c6_addr_ok got %0b want 0", data_if.addr_ok); end
    step();
    axi_if.arready = 1'b0;
    for (int c = 7; c <= 8; c++) begin
      @(negedge clk);
      vec_cnt++; if (axi_if.rready !== 1'b1 || data_if.addr_ok !== 1'b0) begin err_cnt++; $display("FAIL t3_wait%0d got rready %0b addr_ok %0b want 1/0", c, axi_if.rready, data_if.addr_ok); end
      step();
    end
    axi_if.rvalid = 1'b1; axi_if.rdata = 32'hAAAA5555;
    @(negedge clk);
    vec_cnt++; if (data_if.addr_ok !== 1'b0) begin err_cnt++; $display("FAIL t3_c9_addr_ok got %0b want 0", data_if.addr_ok); end
    step();
    axi_if.rvalid = 1'b0;
    @(negedge clk);
    vec_cnt++; if (inst_if.data_ok !== 1'b1 || inst_if.rdata !== 32'hAAAA5555) begin err_cnt++; $display("FAIL t3_c10_inst_done got %0b/%h want 1/aaaa5555", inst_if.data_ok, inst_if.rdata); end
    vec_cnt++; if (data_if.addr_ok !== 1'b1) begin err_cnt++; $display("FAIL t3_c10_data_grant got %0b want 1", data_if.addr_ok); end
    step();
    data_if.req = 1'b0;
    axi_if.arready = 1'b1; axi_if.rvalid = 1'b1; axi_if.rid = 4'd1; axi_if.rdata = 32'h0BADF00D;
    @(negedge clk);
    vec_cnt++; if (axi_if.arid !== 4'd1 || axi_if.araddr !== 32'h3000 || axi_if.arsize !== 3'd1) begin err_cnt++; $display("FAIL t3_c11_ar got %0d/%h/%0d want 1/3000/1", axi_if.arid, axi_if.araddr, axi_if.arsize); end
    step();
    step();
    @(negedge clk);
    vec_cnt++; if (data_if.data_ok !== 1'b1 || data_if.rdata !== 32'h0BADF00D) begin err_cnt++; $display("FAIL t3_c13_data_done got %0b/%h want 1/0badf00d", data_if.data_ok, data_if.rdata); end
    vec_cnt++; if (inst_if.data_ok !== 1'b0 || inst_if.rdata !== 32'hAAAA5555) begin err_cnt++; $display("FAIL t3_c13_inst_kept got %0b/%h want 0/aaaa5555", inst_if.data_ok, inst_if.rdata); end
    vec_cnt++; if (rid_err !== 1'b0) begin err_cnt++; $display("FAIL t3_rid_err got %0b want 0", rid_err); end
  endtask

  task automatic test_rid_err();
    apply_reset();
    inst_if.req = 1'b1; inst_if.addr = 32'h00000100; inst_if.size = 2'd2;
    axi_if.arready = 1'b1; axi_if.rvalid = 1'b1; axi_if.rid = 4'd3; axi_if.rdata = 32'h12345678;
    @(negedge clk);
    vec_cnt++; if (rid_err !== 1'b0) begin err_cnt++; $display("FAIL t4_c0_rid_err got %0b want 0", rid_err); end
    step();
    inst_if.req = 1'b0;
    step();
    step();
    axi_if.rid = 4'd1;
    data_if.req = 1'b1; data_if.addr = 32'h00000200; data_if.size = 2'd2;
    @(negedge clk);
    vec_cnt++; if (inst_if.data_ok !== 1'b1 || inst_if.rdata !== 32'h12345678) begin err_cnt++; $display("FAIL t4_c3_done got %0b/%h want 1/12345678", inst_if.data_ok, inst_if.rdata); end
    vec_cnt++; if (rid_err !== 1'b1) begin err_cnt++; $display("FAIL t4_c3_rid_err got %0b want 1", rid_err); end
    step();
    data_if.req = 1'b0;
    step();
    step();
    @(negedge clk);
    vec_cnt++; if (data_if.data_ok !== 1'b1) begin err_cnt++; $display("FAIL t4_c6_data_ok got %0b want 1", data_if.data_ok); end
    vec_cnt++; if (rid_err !== 1'b1) begin err_cnt++; $display("FAIL t4_c6_rid_sticky got %0b want 1", rid_err); end
    rst = 1'b1;
    #1;
    vec_cnt++; if (rid_err !== 1'b0) begin err_cnt++; $display("FAIL t4_rst_clear got %0b want 0", rid_err); end
    step();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_rst_mid();
    apply_reset();
    inst_if.req = 1'b1; inst_if.addr = 32'h00005000; inst_if.size = 2'd2;
    axi_if.arready = 1'b1;
    @(negedge clk);
    vec_cnt++; if (inst_if.addr_ok !== 1'b1) begin err_cnt++; $display("FAIL t5_c0_addr_ok got %0b want 1", inst_if.addr_ok); end
    step();
    inst_if.req = 1'b0;
    step();
    @(negedge clk);
    vec_cnt++; if (axi_if.rready !== 1'b1) begin err_cnt++; $display("FAIL t5_c2_rready got %0b want 1", axi_if.rready); end
    rst = 1'b1;
    axi_if.rvalid = 1'b1; axi_if.rdata = 32'hDEADBEEF;
    #1;
    vec_cnt++; if (axi_if.rready !== 1'b0 || axi_if.arvalid !== 1'b0) begin err_cnt++; $display("FAIL t5_async_drop got %0b/%0b want 0/0", axi_if.rready, axi_if.arvalid); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec_cnt++; if (inst_if.data_ok !== 1'b0 || axi_if.rready !== 1'b0 || inst_if.rdata !== 32'h0) begin err_cnt++; $display("FAIL t5_abandon%0d got %0b/%0b/%h want 0/0/0", c, inst_if.data_ok, axi_if.rready, inst_if.rdata); end
      step();
    end
    inst_if.req = 1'b1; inst_if.addr = 32'h00006000;
    @(negedge clk);
    vec_cnt++; if (inst_if.addr_ok !== 1'b1) begin err_cnt++; $display("FAIL t5_regrant got %0b want 1", inst_if.addr_ok); end
    step();
    inst_if.req = 1'b0;
    @(negedge clk);
    vec_cnt++; if (axi_if.arvalid !== 1'b1 || axi_if.araddr !== 32'h6000) begin err_cnt++; $display("FAIL t5_regrant_ar got %0b/%h want 1/6000", axi_if.arvalid, axi_if.araddr); end
    step();
    step();
    @(negedge clk);
    vec_cnt++; if (inst_if.data_ok !== 1'b1 || inst_if.rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL t5_redone got %0b/%h want 1/deadbeef", inst_if.data_ok, inst_if.rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    int n_addr;
    int n_data;
    logic exp_a, exp_d;
    n_addr = 0;
    n_data = 0;
    apply_reset();
    inst_if.req = 1'b1; inst_if.addr = 32'h00008000; inst_if.size = 2'd2;
    axi_if.arready = 1'b1; axi_if.rvalid = 1'b1; axi_if.rid = 4'd0;
    for (int c = 0; c <= 30; c++) begin
      axi_if.rdata = 32'hC0DE0000 + 32'(c);
      if (c == 30) inst_if.req = 1'b0;
      exp_a = (c % 3 == 0) && (c < 30);
      exp_d = (c % 3 == 0) && (c > 0);
      @(negedge clk);
      vec_cnt++; if (inst_if.addr_ok !== exp_a || inst_if.data_ok !== exp_d) begin err_cnt++; $display("FAIL t6_c%0d got addr_ok %0b data_ok %0b want %0b/%0b", c, inst_if.addr_ok, inst_if.data_ok, exp_a, exp_d); end
      if (inst_if.addr_ok === 1'b1) n_addr++;
      if (inst_if.data_ok === 1'b1) n_data++;
      step();
    end
    vec_cnt++; if (n_addr != 10 || n_data != 10) begin err_cnt++; $display("FAIL t6_counts got %0d/%0d want 10/10", n_addr, n_data); end
    vec_cnt++; if (inst_if.rdata !== 32'hC0DE001D) begin err_cnt++; $display("FAIL t6_last_rdata got %h want c0de001d", inst_if.rdata); end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_rid_err();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
